// File: rtl/tick_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tick_timer_arbiter
//   Shared timebase controller. One prescaler and one down-counter are
//   time-multiplexed among N_REQ requesters. Each requester asks for a delay
//   of D prescaled ticks and receives a one-cycle done pulse on expiry.
//   tick is a clock-enable pulse, never a clock; everything runs on clk.
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   req     in   [N_REQ]        level request per requester, held until done
//   dly_in  in   [N_REQ*CNT_W]  packed delays, slice i = dly_in[i*CNT_W +: CNT_W]
//   grant   out  [N_REQ]        registered one-hot owner, zero when idle
//   done    out  [N_REQ]        registered one-cycle expiry pulse
//   tick    out                 registered one-cycle pulse per prescaler wrap
//   busy    out                 high whenever the controller is not idle
// ---------------------------------------------------------------------------
module tick_timer_arbiter #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned DIV_W    = 25,
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] dly_in,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   tick,
   output logic                   busy
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   r_done;
   logic               r_tick;
   logic               r_busy;
   logic [DIV_W-1:0]   r_presc;
   logic [CNT_W-1:0]   r_cnt;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_owner;

   logic               w_found;
   logic [PTR_W-1:0]   w_win;
   logic [PTR_W:0]     w_sum;
   logic [N_REQ-1:0]   w_onehot;
   logic [CNT_W-1:0]   w_dly;
   logic [DIV_W-1:0]   w_presc_nxt;
   logic               w_abort;
   logic               w_last_tick;

   // Round-robin scan starting at r_ptr; index kept one bit wider so the
   // modulo wrap is a single conditional subtract.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (w_sum >= (PTR_W+1)'(N_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(N_REQ);
         end
         if (!w_found && req[w_sum[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[PTR_W-1:0];
         end
      end
   end

   assign w_onehot    = N_REQ'(1) << w_win;
   assign w_dly       = dly_in[w_win*CNT_W +: CNT_W];
   assign w_presc_nxt = (r_presc == DIV_W'(TICK_DIV - 1)) ? '0 : r_presc + 1'b1;
   assign w_abort     = ~|(req & r_grant);
   // r_tick is high exactly in the cycle the prescaler sits at TICK_DIV-1,
   // so it doubles as the "on tick" qualifier for the countdown.
   assign w_last_tick = r_tick && (r_cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_done  <= '0;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
         r_presc <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
      end else begin
         r_done <= '0;
         r_tick <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= w_onehot;
                  r_owner <= w_win;
                  r_cnt   <= w_dly;
                  r_presc <= '0;
                  r_busy  <= 1'b1;
                  if (w_dly == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= w_onehot;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // Abort wins over a coincident final tick: no done pulse.
               if (w_abort) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_presc <= w_presc_nxt;
                  // Registered tick: announce next cycle's wrap value now.
                  r_tick  <= (w_presc_nxt == DIV_W'(TICK_DIV - 1));
                  if (r_tick) begin
                     r_cnt <= r_cnt - 1'b1;
                  end
                  if (w_last_tick) begin
                     r_state <= ST_DONE;
                     r_done  <= r_grant;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_ptr   <= (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = r_grant;
   assign done  = r_done;
   assign tick  = r_tick;
   assign busy  = r_busy;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tick_timer_arbiter
//   Directed bench for tick_timer_arbiter with TICK_DIV=4, N_REQ=4, CNT_W=8.
//   Inputs change 1 ns after the rising edge and outputs are sampled there,
//   so the cycle in which inputs are set is the acceptance cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_tick_timer_arbiter;

   localparam int unsigned TD = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] dly_in;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        tick;
   logic        busy;

   int n_checks;
   int n_fail;

   tick_timer_arbiter #(
      .TICK_DIV (TD),
      .DIV_W    (3),
      .N_REQ    (4),
      .CNT_W    (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .dly_in (dly_in),
      .grant  (grant),
      .done   (done),
      .tick   (tick),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called in the acceptance cycle. Walks the whole service of owner g with
   // delay d, drops g's request in the done cycle, ends in the following
   // IDLE cycle (which may itself be the next acceptance cycle).
   task automatic expect_service(input string name, input logic [3:0] g, input int d);
      int last;
      last = d * TD + 1;
      for (int c = 1; c <= last; c++) begin
         step(1);
         check($sformatf("%s_c%0d_grant", name, c), 32'(grant), 32'(g));
         check($sformatf("%s_c%0d_busy", name, c), 32'(busy), 32'd1);
         check($sformatf("%s_c%0d_tick", name, c), 32'(tick),
               32'((d > 0) && (c % TD == 0) && (c <= d * TD)));
         check($sformatf("%s_c%0d_done", name, c), 32'(done),
               (c == last) ? 32'(g) : 32'd0);
         if (c == last) req = req & ~g;
      end
      step(1);
      check($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
      check($sformatf("%s_idle_grant", name), 32'(grant), 32'd0);
      check($sformatf("%s_idle_done", name), 32'(done), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      req      = '0;
      dly_in   = '0;
      step(2);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_tick",  32'(tick),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      step(1);

      // Requester 0, delay 3: ticks at 4,8,12, done at 13, idle at 14.
      dly_in[0*8 +: 8] = 8'd3;
      req = 4'b0001;
      expect_service("d3", 4'b0001, 3);

      // Requester 1, delay 0: grant and done together in cycle 1.
      dly_in[1*8 +: 8] = 8'd0;
      req = 4'b0010;
      expect_service("d0", 4'b0010, 0);

      // Pointer now 2: requester 3 beats requester 0, then 0 is served.
      dly_in[0*8 +: 8] = 8'd1;
      dly_in[3*8 +: 8] = 8'd1;
      req = 4'b1001;
      expect_service("rr3", 4'b1000, 1);
      expect_service("rr0", 4'b0001, 1);

      // Pointer now 1: requester 2 (dly 5) wins, is aborted at cycle 6.
      dly_in[2*8 +: 8] = 8'd5;
      dly_in[3*8 +: 8] = 8'd1;
      req = 4'b1100;
      for (int c = 1; c <= 6; c++) begin
         step(1);
         check($sformatf("ab_c%0d_grant", c), 32'(grant), 32'b0100);
         check($sformatf("ab_c%0d_tick", c), 32'(tick), 32'(c == 4));
         check($sformatf("ab_c%0d_done", c), 32'(done), 32'd0);
      end
      req = 4'b1000;
      step(1);
      check("ab_c7_grant", 32'(grant), 32'd0);
      check("ab_c7_busy",  32'(busy),  32'd0);
      check("ab_c7_done",  32'(done),  32'd0);
      check("ab_c7_tick",  32'(tick),  32'd0);
      expect_service("ab_next3", 4'b1000, 1);

      // Reset mid-run: dly 3 on requester 0, rst during cycle 9.
      dly_in[0*8 +: 8] = 8'd3;
      req = 4'b0001;
      for (int c = 1; c <= 9; c++) begin
         step(1);
         check($sformatf("rs_c%0d_grant", c), 32'(grant), 32'b0001);
         check($sformatf("rs_c%0d_tick", c), 32'(tick), 32'((c == 4) || (c == 8)));
         check($sformatf("rs_c%0d_done", c), 32'(done), 32'd0);
      end
      rst = 1'b1;
      step(1);
      check("rs_c10_grant", 32'(grant), 32'd0);
      check("rs_c10_done",  32'(done),  32'd0);
      check("rs_c10_tick",  32'(tick),  32'd0);
      check("rs_c10_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      step(1);
      check("rs_c11_grant", 32'(grant), 32'b0001);
      check("rs_c11_busy",  32'(busy),  32'd1);
      check("rs_c11_done",  32'(done),  32'd0);
      rst = 1'b1;
      req = '0;
      step(1);
      rst = 1'b0;
      step(1);

      // All four requesting with delay 1: served 0,1,2,3, then wraps to 0.
      dly_in = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1111;
      expect_service("all0", 4'b0001, 1);
      expect_service("all1", 4'b0010, 1);
      expect_service("all2", 4'b0100, 1);
      expect_service("all3", 4'b1000, 1);
      req = 4'b0101;
      expect_service("wrap0", 4'b0001, 1);
      expect_service("wrap2", 4'b0100, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
